// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//
// Control path for a 5-stage RV32I pipeline. It decodes the instruction sitting in
// ID, carries the resulting control bundle through the ID/EX, EX/MEM and MEM/WB
// registers, detects load-use hazards and inserts bubbles on a hazard or EX flush.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   instr_i           ID-stage instruction (bits [31:0] decoded)
//   stall_i           freeze every stage register
//   flush_ex_i        squash the instruction about to enter EX
//   ImmSrc_d_o        immediate format for the ID extender
//                     (000 I, 001 S, 010 B, 011 J, 100 U)
//   hazard_stall_o    load-use stall request to PC / IF-ID
//   *_e_o             EX-stage control fields
//   *_m_o             MEM-stage control fields
//   *_w_o             WB-stage control fields
module pipelined_control_unit #(
    parameter int INSTR_WIDTH    = 32,
    parameter int ALUCTRL_WIDTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INSTR_WIDTH-1:0]    instr_i,
    input  logic                      stall_i,
    input  logic                      flush_ex_i,
    output logic [2:0]                ImmSrc_d_o,
    output logic                      hazard_stall_o,
    output logic [ALUCTRL_WIDTH-1:0]  ALUControl_e_o,
    output logic                      ALUSrc_e_o,
    output logic                      Branch_e_o,
    output logic                      Jump_e_o,
    output logic                      PCSrcReg_e_o,
    output logic [2:0]                func3_e_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_e_o,
    output logic                      illegal_e_o,
    output logic                      MemWrite_m_o,
    output logic                      ByteOp_m_o,
    output logic                      RegWrite_m_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_m_o,
    output logic                      RegWrite_w_o,
    output logic [1:0]                ResultSrc_w_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_w_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // An all-zero value of any bundle is a bubble.
    typedef struct packed {
        logic [ALUCTRL_WIDTH-1:0]  alu_ctrl;
        logic                      alu_src;
        logic                      branch;
        logic                      jump;
        logic                      pc_src_reg;
        logic [2:0]                func3;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      illegal;
        logic                      mem_write;
        logic                      byte_op;
        logic                      reg_write;
        logic [1:0]                result_src;
    } ex_bundle_t;

    typedef struct packed {
        logic                      mem_write;
        logic                      byte_op;
        logic                      reg_write;
        logic [1:0]                result_src;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } mem_bundle_t;

    typedef struct packed {
        logic                      reg_write;
        logic [1:0]                result_src;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } wb_bundle_t;

    logic [6:0] opcode;
    logic [4:0] rd_field;
    logic [4:0] rs1_field;
    logic [4:0] rs2_field;
    logic [2:0] func3_field;
    logic       bit30;

    assign opcode      = instr_i[6:0];
    assign rd_field    = instr_i[11:7];
    assign func3_field = instr_i[14:12];
    assign rs1_field   = instr_i[19:15];
    assign rs2_field   = instr_i[24:20];
    assign bit30       = instr_i[30];

    // Immediate bits are consumed by the datapath extender, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i;

    // SUB exists only for register-register ops; SRA/SRAI share bit 30 in both forms.
    function automatic logic [3:0] alu_from_func(input logic [2:0] f3, input logic b30,
                                                  input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    ex_bundle_t  dec;
    logic [2:0]  imm_src;
    logic        rs1_used;
    logic        rs2_used;
    logic [3:0]  alu_op;

    always_comb begin
        dec        = '0;
        imm_src    = IMM_I;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        alu_op     = ALU_ADD;
        dec.func3  = func3_field;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                alu_op        = alu_from_func(func3_field, bit30, 1'b1);
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                alu_op        = alu_from_func(func3_field, bit30, 1'b0);
                rs1_used      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                dec.byte_op    = (func3_field == 3'b000);
                rs1_used       = 1'b1;
            end
            OP_STORE: begin
                imm_src       = IMM_S;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.byte_op   = (func3_field == 3'b000);
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                imm_src    = IMM_B;
                dec.branch = 1'b1;
                alu_op     = ALU_SUB;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
            OP_JAL: begin
                imm_src        = IMM_J;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_JALR: begin
                dec.jump       = 1'b1;
                dec.pc_src_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                rs1_used       = 1'b1;
            end
            OP_LUI: begin
                imm_src       = IMM_U;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                alu_op        = ALU_PASSB;
            end
            default: begin
                dec.illegal = 1'b1;
                dec.func3   = 3'b000;
            end
        endcase
        dec.alu_ctrl = ALUCTRL_WIDTH'(alu_op);
        // x0 is never written; rd is only carried for instructions that write it,
        // so a load to x0 can never look like a hazard source.
        if (rd_field == 5'd0) begin
            dec.reg_write = 1'b0;
        end
        dec.rd = dec.reg_write ? REG_ADDR_WIDTH'(rd_field) : '0;
    end

    ex_bundle_t  ex_q,  ex_d;
    mem_bundle_t mem_q, mem_d;
    wb_bundle_t  wb_q,  wb_d;

    // A bubble has result_src 00, so result_src==01 already implies a valid load in EX.
    logic rs1_hit;
    logic rs2_hit;
    logic raw;

    assign rs1_hit = rs1_used && (REG_ADDR_WIDTH'(rs1_field) == ex_q.rd);
    assign rs2_hit = rs2_used && (REG_ADDR_WIDTH'(rs2_field) == ex_q.rd);
    assign raw     = (ex_q.result_src == RES_MEM) && (ex_q.rd != '0) && (rs1_hit || rs2_hit);

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!stall_i) begin
            ex_d  = (flush_ex_i || raw) ? '0 : dec;
            mem_d = '{mem_write:  ex_q.mem_write,
                      byte_op:    ex_q.byte_op,
                      reg_write:  ex_q.reg_write,
                      result_src: ex_q.result_src,
                      rd:         ex_q.rd};
            wb_d  = '{reg_write:  mem_q.reg_write,
                      result_src: mem_q.result_src,
                      rd:         mem_q.rd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ImmSrc_d_o     = imm_src;
    // A flushed ID instruction is squashed anyway, so there is nothing to stall for.
    assign hazard_stall_o = raw && !flush_ex_i;

    assign ALUControl_e_o = ex_q.alu_ctrl;
    assign ALUSrc_e_o     = ex_q.alu_src;
    assign Branch_e_o     = ex_q.branch;
    assign Jump_e_o       = ex_q.jump;
    assign PCSrcReg_e_o   = ex_q.pc_src_reg;
    assign func3_e_o      = ex_q.func3;
    assign rd_e_o         = ex_q.rd;
    assign illegal_e_o    = ex_q.illegal;

    assign MemWrite_m_o   = mem_q.mem_write;
    assign ByteOp_m_o     = mem_q.byte_op;
    assign RegWrite_m_o   = mem_q.reg_write;
    assign rd_m_o         = mem_q.rd;

    assign RegWrite_w_o   = wb_q.reg_write;
    assign ResultSrc_w_o  = wb_q.result_src;
    assign rd_w_o         = wb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit
//
// Self-checking bench for pipelined_control_unit. A reference model tracks the
// pipeline as three records (EX, MEM, WB) decoded from the RV32I rules and is
// compared against every DUT output once per cycle. A vector table checks
// individual instruction decodes stage by stage, hand-written sequences cover
// load-use, flush, stall, illegal and reset cases, and a random phase follows.
module tb_pipelined_control_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       pcsrc;
        logic [2:0] f3;
        logic [4:0] rd;
        logic       illegal;
        logic       memw;
        logic       byteop;
        logic       regw;
        logic [1:0] res;
    } ctl_t;

    typedef struct packed {
        ctl_t       c;
        logic [2:0] imm;
        logic       u1;
        logic       u2;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  imm;
        ctl_t        exp;
    } vec_t;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] ADD_X1   = 32'h003100B3;
    localparam logic [31:0] LW_X5    = 32'h0000A283;
    localparam logic [31:0] LW_X0    = 32'h0000A003;
    localparam logic [31:0] ADD_X6U  = 32'h00228333;
    localparam logic [31:0] ADD_X6Z  = 32'h00000333;
    localparam logic [31:0] BEQ      = 32'h00208463;
    localparam logic [31:0] SW       = 32'h0020A223;
    localparam logic [31:0] SB       = 32'h00208223;
    localparam logic [31:0] SRAI     = 32'h40345393;
    localparam logic [31:0] ILLEGAL  = 32'h0000007F;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        flush_ex_i;
    logic [2:0]  ImmSrc_d_o;
    logic        hazard_stall_o;
    logic [3:0]  ALUControl_e_o;
    logic        ALUSrc_e_o;
    logic        Branch_e_o;
    logic        Jump_e_o;
    logic        PCSrcReg_e_o;
    logic [2:0]  func3_e_o;
    logic [4:0]  rd_e_o;
    logic        illegal_e_o;
    logic        MemWrite_m_o;
    logic        ByteOp_m_o;
    logic        RegWrite_m_o;
    logic [4:0]  rd_m_o;
    logic        RegWrite_w_o;
    logic [1:0]  ResultSrc_w_o;
    logic [4:0]  rd_w_o;

    int total = 0;
    int bad   = 0;

    ctl_t m_ex, m_mem, m_wb;
    vec_t vecs[13];
    logic [6:0] rand_ops[10];
    logic [3:0] alu_by_f3[8];

    pipelined_control_unit #(
        .INSTR_WIDTH(32),
        .ALUCTRL_WIDTH(4),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .instr_i(instr_i),
        .stall_i(stall_i),
        .flush_ex_i(flush_ex_i),
        .ImmSrc_d_o(ImmSrc_d_o),
        .hazard_stall_o(hazard_stall_o),
        .ALUControl_e_o(ALUControl_e_o),
        .ALUSrc_e_o(ALUSrc_e_o),
        .Branch_e_o(Branch_e_o),
        .Jump_e_o(Jump_e_o),
        .PCSrcReg_e_o(PCSrcReg_e_o),
        .func3_e_o(func3_e_o),
        .rd_e_o(rd_e_o),
        .illegal_e_o(illegal_e_o),
        .MemWrite_m_o(MemWrite_m_o),
        .ByteOp_m_o(ByteOp_m_o),
        .RegWrite_m_o(RegWrite_m_o),
        .rd_m_o(rd_m_o),
        .RegWrite_w_o(RegWrite_w_o),
        .ResultSrc_w_o(ResultSrc_w_o),
        .rd_w_o(rd_w_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t mk_ctl(input logic [3:0] alu, input logic src, input logic br,
                                    input logic jmp, input logic pcs, input logic [2:0] f3,
                                    input logic [4:0] rd, input logic ill, input logic mw,
                                    input logic bo, input logic rw, input logic [1:0] res);
        ctl_t c;
        c = '{alu: alu, alu_src: src, branch: br, jump: jmp, pcsrc: pcs, f3: f3, rd: rd,
              illegal: ill, memw: mw, byteop: bo, regw: rw, res: res};
        return c;
    endfunction

    // Reference decode: opcode class first, then ALU op from a func3 lookup table.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t       d;
        logic [2:0] f3;
        logic [3:0] base;
        f3   = ins[14:12];
        base = alu_by_f3[f3];
        d    = '0;
        case (ins[6:0])
            7'h33: begin
                d.c.regw = 1; d.u1 = 1; d.u2 = 1;
                d.c.alu  = (ins[30] && f3 == 3'd0) ? 4'd1 : (ins[30] && f3 == 3'd5) ? 4'd8 : base;
            end
            7'h13: begin
                d.c.regw = 1; d.c.alu_src = 1; d.u1 = 1;
                d.c.alu  = (ins[30] && f3 == 3'd5) ? 4'd8 : base;
            end
            7'h03: begin
                d.c.regw = 1; d.c.alu_src = 1; d.c.res = 2'd1; d.u1 = 1;
                d.c.byteop = (f3 == 3'd0);
            end
            7'h23: begin
                d.imm = 3'd1; d.c.memw = 1; d.c.alu_src = 1; d.u1 = 1; d.u2 = 1;
                d.c.byteop = (f3 == 3'd0);
            end
            7'h63: begin
                d.imm = 3'd2; d.c.branch = 1; d.c.alu = 4'd1; d.u1 = 1; d.u2 = 1;
            end
            7'h6F: begin
                d.imm = 3'd3; d.c.jump = 1; d.c.regw = 1; d.c.res = 2'd2;
            end
            7'h67: begin
                d.c.jump = 1; d.c.pcsrc = 1; d.c.alu_src = 1; d.c.regw = 1; d.c.res = 2'd2;
                d.u1 = 1;
            end
            7'h37: begin
                d.imm = 3'd4; d.c.alu_src = 1; d.c.alu = 4'd10; d.c.regw = 1;
            end
            default: d.c.illegal = 1;
        endcase
        if (!d.c.illegal) d.c.f3 = f3;
        if (ins[11:7] == 5'd0) d.c.regw = 0;
        if (d.c.regw) d.c.rd = ins[11:7];
        return d;
    endfunction

    function automatic logic model_raw(input logic [31:0] ins);
        dec_t d;
        d = ref_decode(ins);
        return (m_ex.res == 2'd1) && (m_ex.rd != 5'd0) &&
               ((d.u1 && ins[19:15] == m_ex.rd) || (d.u2 && ins[24:20] == m_ex.rd));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        dec_t d;
        d = ref_decode(instr_i);
        chk("imm_d",     ImmSrc_d_o,     d.imm);
        chk("hazard",    hazard_stall_o, model_raw(instr_i) && !flush_ex_i);
        chk("alu_e",     ALUControl_e_o, m_ex.alu);
        chk("alusrc_e",  ALUSrc_e_o,     m_ex.alu_src);
        chk("branch_e",  Branch_e_o,     m_ex.branch);
        chk("jump_e",    Jump_e_o,       m_ex.jump);
        chk("pcsrc_e",   PCSrcReg_e_o,   m_ex.pcsrc);
        chk("func3_e",   func3_e_o,      m_ex.f3);
        chk("rd_e",      rd_e_o,         m_ex.rd);
        chk("illegal_e", illegal_e_o,    m_ex.illegal);
        chk("memw_m",    MemWrite_m_o,   m_mem.memw);
        chk("byte_m",    ByteOp_m_o,     m_mem.byteop);
        chk("regw_m",    RegWrite_m_o,   m_mem.regw);
        chk("rd_m",      rd_m_o,         m_mem.rd);
        chk("regw_w",    RegWrite_w_o,   m_wb.regw);
        chk("res_w",     ResultSrc_w_o,  m_wb.res);
        chk("rd_w",      rd_w_o,         m_wb.rd);
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic st, input logic fl);
        @(negedge clk);
        instr_i    = ins;
        stall_i    = st;
        flush_ex_i = fl;
        #1;
        checkOutput();
    endtask

    task automatic advanceClock();
        logic raw;
        @(posedge clk);
        if (!rst && !stall_i) begin
            raw   = model_raw(instr_i);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (flush_ex_i || raw) ? ctl_t'('0) : ref_decode(instr_i).c;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_ex = '0; m_mem = '0; m_wb = '0;
        chk("rst_alu_e",  ALUControl_e_o, 0);
        chk("rst_src_e",  ALUSrc_e_o,     0);
        chk("rst_rd_e",   rd_e_o,         0);
        chk("rst_ill_e",  illegal_e_o,    0);
        chk("rst_regw_m", RegWrite_m_o,   0);
        chk("rst_rd_m",   rd_m_o,         0);
        chk("rst_memw_m", MemWrite_m_o,   0);
        chk("rst_regw_w", RegWrite_w_o,   0);
        chk("rst_res_w",  ResultSrc_w_o,  0);
        chk("rst_rd_w",   rd_w_o,         0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_i = NOP; stall_i = 1'b0; flush_ex_i = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        alu_by_f3 = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
        rand_ops  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F, 7'h0B};

        //                        instr          imm   alu src br j pc f3 rd ill mw bo rw res
        vecs[0]  = '{32'h003100B3, 3'd0, mk_ctl(4'd0, 0, 0, 0, 0, 3'd0, 5'd1, 0, 0, 0, 1, 2'd0)};
        vecs[1]  = '{32'h403100B3, 3'd0, mk_ctl(4'd1, 0, 0, 0, 0, 3'd0, 5'd1, 0, 0, 0, 1, 2'd0)};
        vecs[2]  = '{32'h40345393, 3'd0, mk_ctl(4'd8, 1, 0, 0, 0, 3'd5, 5'd7, 0, 0, 0, 1, 2'd0)};
        vecs[3]  = '{32'h0062B233, 3'd0, mk_ctl(4'd9, 0, 0, 0, 0, 3'd3, 5'd4, 0, 0, 0, 1, 2'd0)};
        vecs[4]  = '{32'h123454B7, 3'd4, mk_ctl(4'd10,1, 0, 0, 0, 3'd5, 5'd9, 0, 0, 0, 1, 2'd0)};
        vecs[5]  = '{32'h0000A283, 3'd0, mk_ctl(4'd0, 1, 0, 0, 0, 3'd2, 5'd5, 0, 0, 0, 1, 2'd1)};
        vecs[6]  = '{32'h00208223, 3'd1, mk_ctl(4'd0, 1, 0, 0, 0, 3'd0, 5'd0, 0, 1, 1, 0, 2'd0)};
        vecs[7]  = '{32'h00208463, 3'd2, mk_ctl(4'd1, 0, 1, 0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 2'd0)};
        vecs[8]  = '{32'h000000EF, 3'd3, mk_ctl(4'd0, 0, 0, 1, 0, 3'd0, 5'd1, 0, 0, 0, 1, 2'd2)};
        vecs[9]  = '{32'h000100E7, 3'd0, mk_ctl(4'd0, 1, 0, 1, 1, 3'd0, 5'd1, 0, 0, 0, 1, 2'd2)};
        vecs[10] = '{32'h0000007F, 3'd0, mk_ctl(4'd0, 0, 0, 0, 0, 3'd0, 5'd0, 1, 0, 0, 0, 2'd0)};
        vecs[11] = '{32'h00208033, 3'd0, mk_ctl(4'd0, 0, 0, 0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 2'd0)};
        vecs[12] = '{32'h4020D1B3, 3'd0, mk_ctl(4'd8, 0, 0, 0, 0, 3'd5, 5'd3, 0, 0, 0, 1, 2'd0)};

        applyReset();

        // Decode table: each instruction followed by NOPs, checked at EX, MEM and WB.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].instr, 0, 0);
            chk("tbl_imm", ImmSrc_d_o, vecs[i].imm);
            advanceClock();
            applyStimulus(NOP, 0, 0);
            chk("tbl_alu_e",  ALUControl_e_o, vecs[i].exp.alu);
            chk("tbl_src_e",  ALUSrc_e_o,     vecs[i].exp.alu_src);
            chk("tbl_br_e",   Branch_e_o,     vecs[i].exp.branch);
            chk("tbl_jmp_e",  Jump_e_o,       vecs[i].exp.jump);
            chk("tbl_pcs_e",  PCSrcReg_e_o,   vecs[i].exp.pcsrc);
            chk("tbl_f3_e",   func3_e_o,      vecs[i].exp.f3);
            chk("tbl_rd_e",   rd_e_o,         vecs[i].exp.rd);
            chk("tbl_ill_e",  illegal_e_o,    vecs[i].exp.illegal);
            advanceClock();
            applyStimulus(NOP, 0, 0);
            chk("tbl_memw_m", MemWrite_m_o,   vecs[i].exp.memw);
            chk("tbl_byte_m", ByteOp_m_o,     vecs[i].exp.byteop);
            chk("tbl_regw_m", RegWrite_m_o,   vecs[i].exp.regw);
            advanceClock();
            applyStimulus(NOP, 0, 0);
            chk("tbl_regw_w", RegWrite_w_o,   vecs[i].exp.regw);
            chk("tbl_res_w",  ResultSrc_w_o,  vecs[i].exp.res);
            chk("tbl_rd_w",   rd_w_o,         vecs[i].exp.rd);
            advanceClock();
        end

        // Mid-stream reset with ADDs in flight, then the first ADD after release.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ADD_X1, 0, 0);
            advanceClock();
        end
        applyStimulus(NOP, 0, 0);
        chk("pre_rst_regw_w", RegWrite_w_o, 1);
        applyReset();
        applyStimulus(ADD_X1, 0, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("post_rst_alu_e", ALUControl_e_o, 0);
        chk("post_rst_rd_e",  rd_e_o, 1);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("post_rst_regw_w", RegWrite_w_o, 1);
        chk("post_rst_rd_w",   rd_w_o, 1);
        advanceClock();

        // Load-use: one stall cycle, one bubble, then the ADD.
        applyStimulus(LW_X5, 0, 0);
        advanceClock();
        applyStimulus(ADD_X6U, 0, 0);
        chk("lu_hazard", hazard_stall_o, 1);
        advanceClock();
        applyStimulus(ADD_X6U, 0, 0);
        chk("lu_hazard_once", hazard_stall_o, 0);
        chk("lu_bubble_rd_e", rd_e_o, 0);
        chk("lu_bubble_regw_m", RegWrite_m_o, 1);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("lu_add_rd_e", rd_e_o, 6);
        chk("lu_res_w", ResultSrc_w_o, 1);
        chk("lu_rd_w", rd_w_o, 5);
        advanceClock();

        // No hazard when the consumer ignores the load result or the load targets x0.
        applyStimulus(LW_X5, 0, 0);
        advanceClock();
        applyStimulus(ADD_X6Z, 0, 0);
        chk("nouse_hazard", hazard_stall_o, 0);
        advanceClock();
        applyStimulus(LW_X0, 0, 0);
        advanceClock();
        applyStimulus(ADD_X6Z, 0, 0);
        chk("ldx0_hazard", hazard_stall_o, 0);
        advanceClock();

        // Branch taken in EX squashes the store behind it.
        applyStimulus(BEQ, 0, 0);
        advanceClock();
        applyStimulus(SW, 0, 1);
        chk("flush_br_e", Branch_e_o, 1);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("flush_bubble_br_e", Branch_e_o, 0);
        chk("flush_bubble_src_e", ALUSrc_e_o, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("flush_memw_m", MemWrite_m_o, 0);
        advanceClock();

        // Flush and load-use together: no stall, bubble enters EX.
        applyStimulus(LW_X5, 0, 0);
        advanceClock();
        applyStimulus(ADD_X6U, 0, 1);
        chk("flush_raw_hazard", hazard_stall_o, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("flush_raw_rd_e", rd_e_o, 0);
        advanceClock();

        // External stall holds SRAI in EX for three cycles.
        applyStimulus(SRAI, 0, 0);
        advanceClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NOP, 1, 0);
            chk("stall_alu_e", ALUControl_e_o, 4'd8);
            advanceClock();
        end
        applyStimulus(NOP, 0, 0);
        chk("stall_release_alu_e", ALUControl_e_o, 4'd8);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("stall_resume_rd_m", rd_m_o, 7);
        chk("stall_resume_regw_m", RegWrite_m_o, 1);
        advanceClock();

        // Illegal opcode is a one-cycle level in EX with no side effects.
        applyStimulus(ILLEGAL, 0, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("ill_e", illegal_e_o, 1);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("ill_e_clear", illegal_e_o, 0);
        chk("ill_regw_m", RegWrite_m_o, 0);
        chk("ill_memw_m", MemWrite_m_o, 0);
        advanceClock();
        applyStimulus(SB, 0, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        advanceClock();
        applyStimulus(NOP, 0, 0);
        chk("sb_byte_m", ByteOp_m_o, 1);
        chk("sb_memw_m", MemWrite_m_o, 1);
        advanceClock();

        // Random instruction stream with small register indices to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w        = $urandom;
            w[6:0]   = rand_ops[$urandom_range(0, 9)];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            applyStimulus(w, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            advanceClock();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Successor to the single-cycle RV32I control decoder for the 5-stage pipeline.
- Decodes the ID-stage instruction and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, inserts bubbles on hazard or flush, and freezes on external stall.
- ALU control width and register-address width are parametrised; this generation adds SLTU, SRA and LUI, plus an illegal-opcode flag.

Parameters:
INSTR_WIDTH, 32, instruction width (only bits [31:0] decoded)
ALUCTRL_WIDTH, 4, ALUControl width (min 4)
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_i  in  INSTR_WIDTH  ID-stage instruction
stall_i  in  1  freeze all stage registers
flush_ex_i  in  1  branch/jump taken in EX; squash instruction entering EX
ImmSrc_d_o  out  3  immediate type for ID-stage extender (combinational)
hazard_stall_o  out  1  load-use stall request to PC/IF-ID (combinational)
ALUControl_e_o  out  ALUCTRL_WIDTH  EX ALU operation
ALUSrc_e_o  out  1  EX ALU operand B = immediate
Branch_e_o  out  1  EX conditional branch
Jump_e_o  out  1  EX JAL/JALR
PCSrcReg_e_o  out  1  EX target from rs1 (JALR)
func3_e_o  out  3  EX branch condition
rd_e_o  out  REG_ADDR_WIDTH  EX destination
illegal_e_o  out  1  EX holds undecodable opcode
MemWrite_m_o  out  1  MEM store enable
ByteOp_m_o  out  1  MEM byte access
RegWrite_m_o  out  1  MEM write-back pending (forwarding)
rd_m_o  out  REG_ADDR_WIDTH  MEM destination
RegWrite_w_o  out  1  WB register write enable
ResultSrc_w_o  out  2  WB select: 00 ALU, 01 memory, 10 PC+4
rd_w_o  out  REG_ADDR_WIDTH  WB destination

Behaviour:

Decode (combinational, ID):
- opcode = instr[6:0], rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20].
- R 0110011 / I-ALU 0010011: RegWrite=1, ALUSrc = (I-ALU), ResultSrc=00.
- LOAD 0000011: ImmSrc I, RegWrite=1, ALUSrc=1, ALU ADD, ResultSrc=01.
- STORE 0100011: ImmSrc S, MemWrite=1, ALUSrc=1, ALU ADD.
- BRANCH 1100011: ImmSrc B, Branch=1, ALU SUB.
- JAL 1101111: ImmSrc J, Jump=1, RegWrite=1, ResultSrc=10.
- JALR 1100111: ImmSrc I, Jump=1, PCSrcReg=1, ALUSrc=1, RegWrite=1, ResultSrc=10.
- LUI 0110111: ImmSrc U, ALUSrc=1, ALU PASSB, RegWrite=1.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001, PASSB 1010; zero-extended to ALUCTRL_WIDTH.
- func3/func7 mapping: SUB when R-type and instr[30]=1; SRA when func3=101 and instr[30]=1 (R or I).
- ByteOp = 1 for LOAD/STORE with func3=000, else 0.
- Any other opcode: illegal=1, all enables 0, ImmSrc=000.
- RegWrite forced 0 when rd=0.

Hazard:
- raw = EX valid AND EX ResultSrc=01 AND rd_e≠0 AND ((rs1 used AND rs1=rd_e) OR (rs2 used AND rs2=rd_e)).
- rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR; rs2 used by R, STORE, BRANCH.
- hazard_stall_o = raw AND NOT flush_ex_i.

Stage update (rising clk), priority rst > stall_i > others:
- rst (async): every stage register is a bubble (all enables 0, ALUControl 0, ResultSrc 00, rd 0, func3 0, illegal 0); all registered outputs read 0 the cycle reset asserts. A mid-operation reset discards all in-flight instructions.
- stall_i=1: all three registers hold; hazard_stall_o still computed from held EX.
- Otherwise MEM→WB and EX→MEM always advance, and ID→EX takes:
  - a bubble if flush_ex_i OR raw;
  - else the decoded bundle.
- Bubble forwarded through MEM/WB as all-zero.
- Latency: a decoded field appears at EX 1 cycle, MEM 2 cycles, WB 3 cycles after the ID cycle.
- illegal_e_o is a level held while the instruction is in EX; the bubble carries no side effects downstream.

Test Plan:
- Reset asserted mid-stream with ADD in EX/MEM/WB → all outputs 0 immediately; after release, first ADD x1,x2,x3 (0x003100B3) gives ALUControl_e=0000 at +1, RegWrite_w=1, rd_w=1 at +3.
- LW x5,0(x1) followed by ADD x6,x5,x2 → hazard_stall_o=1 for exactly one cycle; EX holds bubble next cycle; ADD reaches EX one cycle later; ResultSrc_w=01 for LW.
- LW x5 followed by ADD x6,x0,x0 (no use) or LW x0 → hazard_stall_o stays 0.
- BEQ in EX with flush_ex_i=1 while SW in ID → EX next cycle is bubble, MemWrite_m never 1; with flush and raw together, hazard_stall_o=0.
- stall_i=1 for 3 cycles during SRAI (func3=101, instr[30]=1) → ALUControl_e=1000 held throughout; pipeline resumes unchanged.
- Opcode 0x7F → illegal_e_o=1 for one cycle, RegWrite/MemWrite 0 in all stages; SB (func3=000) → ByteOp_m=1, MemWrite_m=1.
